// File: rtl/ws2812_frame_seq_if.sv
// Host-side bus of the WS2812 frame sequencer.
// The master drives buffer writes and frame starts. The slave drives
// frame status and the per-pixel hand-off to the serializer.
interface ws2812_frame_seq_if #(
  parameter int ADDR_W = 3
) ();
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              start;
  logic              busy;
  logic              frame_done;
  logic [23:0]       pix_color;
  logic              pix_load;

  modport master (
    output wr_en, wr_addr, wr_data, start,
    input  busy, frame_done, pix_color, pix_load
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    output busy, frame_done, pix_color, pix_load
  );
endinterface

// File: rtl/ws2812_frame_seq.sv
// WS2812 frame sequencer.
// Holds an RGB frame buffer and feeds one pixel at a time to the
// single-pixel serializer. Pixel loads are spaced exactly one pixel slot
// apart. A latch gap follows the last pixel, and then a one-cycle
// frame_done pulse is issued.
module ws2812_frame_seq #(
  parameter int NUM_PIXELS   = 8,
  parameter int ADDR_W       = 3,
  parameter int PIXEL_CYCLES = 3024,
  parameter int LATCH_CYCLES = 6000
) (
  input logic              clk,
  input logic              rst_n,
  ws2812_frame_seq_if.slave bus
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int MAX_CYC = (PIXEL_CYCLES > LATCH_CYCLES) ? PIXEL_CYCLES : LATCH_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // One bit per address: set where the address maps to a real LED.
  function automatic logic [DEPTH-1:0] valid_mask();
    logic [DEPTH-1:0] m;
    m = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = (i < NUM_PIXELS) ? 1'b1 : 1'b0;
    end
    return m;
  endfunction

  localparam logic [DEPTH-1:0] VALID_MASK = valid_mask();

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] idx_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              busy_r;
  logic              frame_done_r;
  logic              pix_load_r;
  logic [23:0]       pix_color_r;
  logic [23:0]       mem_r [DEPTH];
  logic              wr_in_range_s;

  // Writes to addresses past the last LED are dropped.
  // Entries beyond NUM_PIXELS are never written and stay zero.
  assign wr_in_range_s = VALID_MASK[bus.wr_addr];

  // Frame buffer: the host may write it at any time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 24'd0;
      end
    end else if (bus.wr_en && wr_in_range_s) begin
      mem_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Frame sequencing FSM with registered outputs.
  // pix_color is captured on the edge that enters LOAD. A write landing on
  // that same edge is therefore not seen, and the old colour is sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      idx_r        <= '0;
      cnt_r        <= '0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      pix_load_r   <= 1'b0;
      pix_color_r  <= 24'd0;
    end else begin
      pix_load_r   <= 1'b0;
      frame_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r     <= ST_LOAD;
            idx_r       <= '0;
            busy_r      <= 1'b1;
            pix_load_r  <= 1'b1;
            pix_color_r <= mem_r[0];
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          state_r <= ST_SEND;
          cnt_r   <= CNT_W'(1);
        end
        ST_SEND: begin
          if (cnt_r == CNT_W'(PIXEL_CYCLES - 1)) begin
            if (idx_r < ADDR_W'(NUM_PIXELS - 1)) begin
              idx_r       <= idx_r + ADDR_W'(1);
              state_r     <= ST_LOAD;
              pix_load_r  <= 1'b1;
              pix_color_r <= mem_r[idx_r + ADDR_W'(1)];
            end else begin
              state_r <= ST_LATCH;
              cnt_r   <= '0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_LATCH: begin
          if (cnt_r == CNT_W'(LATCH_CYCLES - 1)) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.frame_done = frame_done_r;
  assign bus.pix_load   = pix_load_r;
  assign bus.pix_color  = pix_color_r;

endmodule
